// File: rtl/mult_err_pkg.sv
// Shared types, default widths and helpers for the approximate-multiplier error monitor.
package mult_err_pkg;

  localparam int unsigned W_DEF     = 8;
  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned ACC_W_DEF = 32;

  // Width used by abs_diff; wide enough for any supported product width
  localparam int unsigned ABS_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Unsigned |a-b|; the compare picks the subtraction order so no borrow is ever produced
  function automatic logic [ABS_W-1:0] abs_diff(input logic [ABS_W-1:0] a,
                                                input logic [ABS_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/mult_err_dp.sv
// Two-stage datapath: S1 exact multiply, S2 absolute error and statistic accumulation.
module mult_err_dp
  import mult_err_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clear,
  input  logic               i_xfer,
  input  logic [W-1:0]       i_a,
  input  logic [W-1:0]       i_b,
  input  logic [2*W-1:0]     i_r,
  output logic [CNT_W-1:0]   o_err_count,
  output logic [ACC_W-1:0]   o_sum_abs_err,
  output logic [2*W-1:0]     o_max_abs_err
);

  localparam int unsigned PW = 2 * W;

  logic [PW-1:0]    r_exact;
  logic [PW-1:0]    r_r;
  logic             r_v1;
  logic [CNT_W-1:0] r_err_count;
  logic [ACC_W-1:0] r_sum;
  logic [PW-1:0]    r_max;
  logic [PW-1:0]    w_d;

  assign w_d = PW'(abs_diff(ABS_W'(r_exact), ABS_W'(r_r)));

  // S1: register the exact product and the approximate result of each accepted sample
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v1    <= 1'b0;
      r_exact <= '0;
      r_r     <= '0;
    end else begin
      r_v1 <= i_xfer;
      if (i_xfer) begin
        r_exact <= PW'(i_a) * PW'(i_b);
        r_r     <= i_r;
      end
    end
  end

  // S2: fold the error distance of the sample in S1 into the run statistics
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_err_count <= '0;
      r_sum       <= '0;
      r_max       <= '0;
    end else if (r_v1) begin
      if (w_d != '0) r_err_count <= r_err_count + CNT_W'(1);
      r_sum <= r_sum + ACC_W'(w_d);
      if (w_d > r_max) r_max <= w_d;
    end
  end

  assign o_err_count   = r_err_count;
  assign o_sum_abs_err = r_sum;
  assign o_max_abs_err = r_max;

endmodule

// File: rtl/mult_err_monitor.sv
// Run-control FSM and handshake for the approximate-multiplier error monitor.
module mult_err_monitor
  import mult_err_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_samples,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       A,
  input  logic [W-1:0]       B,
  input  logic [2*W-1:0]     R,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   err_count,
  output logic [ACC_W-1:0]   sum_abs_err,
  output logic [2*W-1:0]     max_abs_err
);

  // The sum must hold (2**CNT_W-1) worst-case errors without wrapping
  if (ACC_W < 2 * W + CNT_W) begin : g_acc_w_check
    $error("mult_err_monitor: ACC_W too small for W and CNT_W");
  end

  state_t           r_state;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_accepted;
  logic             r_in_ready;
  logic             r_busy;
  logic             r_done;
  logic             w_xfer;
  logic             w_clear;
  logic             w_last;

  assign w_xfer  = in_valid && r_in_ready;
  assign w_clear = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last  = w_xfer && (r_accepted == (r_num - CNT_W'(1)));

  // Run control: arm on start, count accepts, drain the pipeline, then hold DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_num      <= '0;
      r_accepted <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_num      <= num_samples;
            r_accepted <= '0;
            if (num_samples == '0) begin
              r_state    <= DONE;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_state    <= RUN;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b1;
              r_done     <= 1'b0;
            end
          end
        end
        RUN: begin
          if (w_xfer) r_accepted <= r_accepted + CNT_W'(1);
          if (w_last) begin
            r_state    <= DRAIN;
            r_in_ready <= 1'b0;
          end
        end
        DRAIN: begin
          // Last sample is in S1 now and lands in the stats on this edge
          r_state <= DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = r_in_ready;
  assign busy     = r_busy;
  assign done     = r_done;

  mult_err_dp #(
    .W     (W),
    .CNT_W (CNT_W),
    .ACC_W (ACC_W)
  ) u_dp (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_clear       (w_clear),
    .i_xfer        (w_xfer),
    .i_a           (A),
    .i_b           (B),
    .i_r           (R),
    .o_err_count   (err_count),
    .o_sum_abs_err (sum_abs_err),
    .o_max_abs_err (max_abs_err)
  );

endmodule

// File: tb/tb_mult_err_monitor.sv
// Self-checking bench for mult_err_monitor against a plain-arithmetic statistics model.
module tb_mult_err_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_samples;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [15:0] R;
  logic        busy;
  logic        done;
  logic [15:0] err_count;
  logic [31:0] sum_abs_err;
  logic [15:0] max_abs_err;

  int errors = 0;
  int checks = 0;

  logic [7:0]  sa [0:3999];
  logic [7:0]  sb [0:3999];
  logic [15:0] sr [0:3999];

  longint m_err, m_sum, m_max;

  mult_err_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_samples (num_samples),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .A           (A),
    .B           (B),
    .R           (R),
    .busy        (busy),
    .done        (done),
    .err_count   (err_count),
    .sum_abs_err (sum_abs_err),
    .max_abs_err (max_abs_err)
  );

  always #5 clk = ~clk;

  // Advance one clock; the bench drives and samples 1 ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fold one accepted sample into the model using plain integer arithmetic
  task automatic model_add(input int a, input int b, input int r);
    longint exact, d;
    exact = longint'(a) * longint'(b);
    d = (exact > r) ? exact - r : r - exact;
    if (d != 0) m_err++;
    m_sum += d;
    if (d > m_max) m_max = d;
  endtask

  // Drive one full run of n (>0) samples from the sample tables and check it end to end.
  // vmode: 0 valid always, 1 alternate 1010..., 2 random. inj >= 0 pulses start at that accept count.
  task automatic do_run(input int n, input int vmode, input int inj);
    int acc = 0;
    int cyc = 0;
    bit tog = 1'b1;
    bit v;
    bit injected = 1'b0;
    m_err = 0; m_sum = 0; m_max = 0;
    start = 1'b1; num_samples = 16'(n); in_valid = 1'b0;
    step();
    start = 1'b0;
    checks++;
    if (err_count !== 16'd0 || sum_abs_err !== 32'd0 || max_abs_err !== 16'd0) begin
      errors++;
      $display("FAIL run_clear: got err=%0d sum=%0d max=%0d, want all 0", err_count, sum_abs_err, max_abs_err);
    end
    while (acc < n && cyc < 4 * n + 20) begin
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL run_handshake acc=%0d: got ready=%b busy=%b done=%b, want 1 1 0", acc, in_ready, busy, done);
      end
      case (vmode)
        0:       v = 1'b1;
        1:       v = tog;
        default: v = 1'($urandom_range(0, 1));
      endcase
      tog = ~tog;
      if (inj >= 0 && acc == inj && !injected) begin
        start = 1'b1; num_samples = 16'd1; injected = 1'b1;
      end
      in_valid = v;
      if (v) begin
        A = sa[acc]; B = sb[acc]; R = sr[acc];
        model_add(int'(sa[acc]), int'(sb[acc]), int'(sr[acc]));
        acc++;
      end else begin
        A = 8'($urandom); B = 8'($urandom); R = 16'($urandom);
      end
      step();
      start = 1'b0;
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (acc < n) begin
      errors++;
      $display("FAIL run_timeout: accepted %0d, want %0d", acc, n);
    end
    // Cycle after the last accept: DRAIN
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL run_drain: got ready=%b busy=%b done=%b, want 0 1 0", in_ready, busy, done);
    end
    step();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL run_done: got done=%b busy=%b ready=%b, want 1 0 0", done, busy, in_ready);
    end
    checks++;
    if (err_count !== 16'(m_err)) begin
      errors++;
      $display("FAIL run_err_count: got %0d, want %0d", err_count, m_err);
    end
    checks++;
    if (sum_abs_err !== 32'(m_sum)) begin
      errors++;
      $display("FAIL run_sum_abs_err: got %0d, want %0d", sum_abs_err, m_sum);
    end
    checks++;
    if (max_abs_err !== 16'(m_max)) begin
      errors++;
      $display("FAIL run_max_abs_err: got %0d, want %0d", max_abs_err, m_max);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; num_samples = '0; in_valid = 1'b0; A = '0; B = '0; R = '0;
    step(); step();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got ready=%b busy=%b done=%b, want 0 0 0", in_ready, busy, done);
    end
    checks++;
    if (err_count !== 16'd0 || sum_abs_err !== 32'd0 || max_abs_err !== 16'd0) begin
      errors++;
      $display("FAIL reset_stats: got err=%0d sum=%0d max=%0d, want 0 0 0", err_count, sum_abs_err, max_abs_err);
    end
  endtask

  task automatic test_exact();
    for (int i = 0; i < 4; i++) begin
      sa[i] = 8'($urandom); sb[i] = 8'($urandom);
      sr[i] = 16'(int'(sa[i]) * int'(sb[i]));
    end
    do_run(4, 0, -1);
  endtask

  task automatic test_known();
    sa[0] = 8'd15;  sb[0] = 8'd15;  sr[0] = 16'd200;
    sa[1] = 8'd255; sb[1] = 8'd255; sr[1] = 16'd65025;
    sa[2] = 8'd10;  sb[2] = 8'd3;   sr[2] = 16'd40;
    do_run(3, 0, -1);
    checks++;
    if (err_count !== 16'd2 || sum_abs_err !== 32'd35 || max_abs_err !== 16'd25) begin
      errors++;
      $display("FAIL known_vectors: got err=%0d sum=%0d max=%0d, want 2 35 25", err_count, sum_abs_err, max_abs_err);
    end
  endtask

  task automatic test_toggle_valid();
    // Every sample is off by one, so err_count equals the number of transfers
    for (int i = 0; i < 5; i++) begin
      sa[i] = 8'($urandom); sb[i] = 8'($urandom);
      sr[i] = 16'(int'(sa[i]) * int'(sb[i]) + 1);
    end
    do_run(5, 1, -1);
    checks++;
    if (err_count !== 16'd5) begin
      errors++;
      $display("FAIL toggle_transfers: got %0d, want 5", err_count);
    end
  endtask

  task automatic test_zero_samples();
    start = 1'b1; num_samples = 16'd0;
    step();
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: got done=%b busy=%b ready=%b, want 1 0 0", done, busy, in_ready);
    end
    checks++;
    if (err_count !== 16'd0 || sum_abs_err !== 32'd0 || max_abs_err !== 16'd0) begin
      errors++;
      $display("FAIL zero_stats: got err=%0d sum=%0d max=%0d, want 0 0 0", err_count, sum_abs_err, max_abs_err);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (in_ready !== 1'b0 || done !== 1'b1) begin
        errors++;
        $display("FAIL zero_hold: got ready=%b done=%b, want 0 1", in_ready, done);
      end
    end
  endtask

  task automatic test_start_and_rst_midrun();
    for (int i = 0; i < 6; i++) begin
      sa[i] = 8'($urandom); sb[i] = 8'($urandom); sr[i] = 16'($urandom);
    end
    do_run(6, 0, 2);
    // Second run: two erroneous samples, then rst mid-run
    sa[0] = 8'd20; sb[0] = 8'd20; sr[0] = 16'd390;
    sa[1] = 8'd7;  sb[1] = 8'd9;  sr[1] = 16'd70;
    start = 1'b1; num_samples = 16'd5;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; A = sa[i]; B = sb[i]; R = sr[i];
      step();
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (err_count !== 16'd2 || sum_abs_err !== 32'd17 || max_abs_err !== 16'd10 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrun_stats: got err=%0d sum=%0d max=%0d busy=%b, want 2 17 10 1", err_count, sum_abs_err, max_abs_err, busy);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        err_count !== 16'd0 || sum_abs_err !== 32'd0 || max_abs_err !== 16'd0) begin
      errors++;
      $display("FAIL midrun_rst: got ready=%b busy=%b done=%b err=%0d sum=%0d max=%0d, want all 0",
               in_ready, busy, done, err_count, sum_abs_err, max_abs_err);
    end
  endtask

  task automatic test_random_long();
    int exact;
    for (int i = 0; i < 3000; i++) begin
      sa[i] = 8'($urandom); sb[i] = 8'($urandom);
      exact = int'(sa[i]) * int'(sb[i]);
      case ($urandom_range(0, 3))
        0:       sr[i] = 16'(exact);
        1:       sr[i] = 16'(exact) ^ 16'($urandom_range(0, 255));
        2:       sr[i] = 16'(exact) & 16'hFF00;
        default: sr[i] = 16'($urandom);
      endcase
    end
    do_run(3000, 2, -1);
    // Restart from DONE with exact samples: stats must come back as zero
    for (int i = 0; i < 2; i++) begin
      sa[i] = 8'($urandom); sb[i] = 8'($urandom);
      sr[i] = 16'(int'(sa[i]) * int'(sb[i]));
    end
    do_run(2, 0, -1);
  endtask

  initial begin
    test_reset();
    test_exact();
    test_known();
    test_toggle_valid();
    test_zero_samples();
    test_start_and_rst_midrun();
    test_random_long();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
